// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with read-only masking and per-register write strobes.
// Define AXIL_REGBANK_IRQ_EN to turn the top two registers into irq enable and W1C status.
module axil_regbank #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(3)
) (
    input  logic                    axi_aclk,
    input  logic                    axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [NUM_REGS*32-1:0]  slv_reg,
    input  logic [NUM_REGS*32-1:0]  slv_read,
`ifdef AXIL_REGBANK_IRQ_EN
    input  logic [NUM_REGS/2-1:0]   irq_src,
    output logic                    irq,
`endif
    output logic [NUM_REGS-1:0]     wr_pulse
);
    localparam int IW = ADDR_WIDTH - 2;
`ifdef AXIL_REGBANK_IRQ_EN
    localparam logic [NUM_REGS-1:0] RO = RO_MASK & ~(NUM_REGS'(3) << (NUM_REGS - 2));
`else
    localparam logic [NUM_REGS-1:0] RO = RO_MASK;
`endif
    logic [31:0] regs [NUM_REGS];
    logic rdy_en, aw_full, w_full, commit, aw_hs, w_hs, ar_hs, aw_ok, ar_ok, unused_ok;
    logic [IW-1:0] aw_idx;
    logic [31:0] w_data, rd_mux;
    logic [3:0] w_strb;
    logic [NUM_REGS-1:0] we;

    // readies stay low until the first edge after reset releases
    assign s_axi_awready = rdy_en & ~aw_full & ~s_axi_bvalid;
    assign s_axi_wready  = rdy_en & ~w_full & ~s_axi_bvalid;
    assign s_axi_arready = rdy_en & ~s_axi_rvalid;
    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = aw_full & w_full;
    assign aw_ok  = 32'(aw_idx) < NUM_REGS;
    assign ar_ok  = 32'(s_axi_araddr[ADDR_WIDTH-1:2]) < NUM_REGS;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], slv_read};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign slv_reg[32*g+:32] = regs[g];
    end

    always_comb begin
        we = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            we[i] = commit & aw_ok & (32'(aw_idx) == i) & ~RO[i];
            if (32'(s_axi_araddr[ADDR_WIDTH-1:2]) == i)
                rd_mux = RO[i] ? slv_read[32*i+:32] : regs[i];
        end
    end

`ifdef AXIL_REGBANK_IRQ_EN
    localparam int NI = NUM_REGS / 2 > 32 ? 32 : NUM_REGS / 2;
    logic [NI-1:0] src_q;
    logic [31:0] rise, lane_mask;
    assign rise = 32'(irq_src[NI-1:0] & ~src_q);
    assign lane_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            src_q <= '0;
            irq   <= 1'b0;
        end else begin
            src_q <= irq_src[NI-1:0];
            irq   <= |(regs[NUM_REGS-1] & regs[NUM_REGS-2]);
        end
    end
`endif

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            rdy_en       <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            wr_pulse     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            rdy_en   <= 1'b1;
            wr_pulse <= we & {NUM_REGS{|w_strb}};
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= aw_ok ? 2'b00 : 2'b10;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < 4; k++)
                    if (we[i] && w_strb[k]) regs[i][8*k+:8] <= w_data[8*k+:8];
`ifdef AXIL_REGBANK_IRQ_EN
            // status is write-one-to-clear; a new edge overrides a same-cycle clear
            regs[NUM_REGS-1] <= (regs[NUM_REGS-1] & ~(we[NUM_REGS-1] ? w_data & lane_mask : 32'h0)) | rise;
`endif
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
            s_axi_rresp  <= ar_ok ? 2'b00 : 2'b10;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: directed self-checking bench for axil_regbank (default build, 16 regs, 7-bit
// addresses so that 0x40 decodes to out-of-range index 16).
module tb_axil_regbank;
    localparam int N  = 16;
    localparam int AW = 7;
    logic axi_aclk = 1'b0, axi_areset = 1'b0;
    logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [2:0] s_axi_awprot = '0, s_axi_arprot = '0;
    logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
    logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [31:0] s_axi_wdata = '0, s_axi_rdata;
    logic [3:0] s_axi_wstrb = '0;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic [N*32-1:0] slv_reg, slv_read;
    logic [N-1:0] wr_pulse;
    logic [31:0] exp_r [N];
    int vectors = 0, errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    axil_regbank #(.NUM_REGS(N), .ADDR_WIDTH(AW)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .slv_reg(slv_reg), .slv_read(slv_read), .wr_pulse(wr_pulse)
    );

    function automatic logic [N*32-1:0] packed_exp();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i+:32] = exp_r[i];
        return v;
    endfunction

    task automatic tick;
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output bit ok);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick;
            ok = s_axi_bvalid;
        end
        resp = s_axi_bresp;
        s_axi_bready = 1;
        tick;
        s_axi_bready = 0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
        s_axi_araddr = a; s_axi_arvalid = 1;
        tick;
        s_axi_arvalid = 0;
        ok = s_axi_rvalid; d = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1;
        tick;
        s_axi_rready = 0;
    endtask

    task automatic test_reset;
        #1 axi_areset = 1;
        #1;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
        end
        tick;
        vectors++;
        if (slv_reg !== '0 || wr_pulse !== '0 || s_axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: slv_reg=%h wr_pulse=%h awready=%b want all 0", slv_reg, wr_pulse, s_axi_awready);
        end
        #1 axi_areset = 0;
        tick;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: readies %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_same_cycle;
        s_axi_awaddr = 7'h08; s_axi_wdata = 32'hA5A5_1234; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        vectors++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_early_b: bvalid %b want 0", s_axi_bvalid);
        end
        tick;
        exp_r[2] = 32'hA5A5_1234;
        vectors++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || wr_pulse !== 16'h0004 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL same_cycle_commit: bvalid=%b bresp=%b pulse=%h reg2=%h want 1 00 0004 a5a51234",
                     s_axi_bvalid, s_axi_bresp, wr_pulse, slv_reg[64+:32]);
        end
        s_axi_bready = 1;
        tick;
        s_axi_bready = 0;
        vectors++;
        if (s_axi_bvalid !== 1'b0 || wr_pulse !== 16'h0000) begin
            errors++;
            $display("FAIL same_cycle_after: bvalid=%b pulse=%h want 0 0000", s_axi_bvalid, wr_pulse);
        end
    endtask

    task automatic test_strobe;
        logic [1:0] resp;
        bit ok;
        wr(7'h0C, 32'h1111_1111, 4'hF, resp, ok);
        exp_r[3] = 32'h1111_1111;
        s_axi_wdata = 32'h0000_FF00; s_axi_wstrb = 4'h2; s_axi_wvalid = 1;
        tick;
        s_axi_wvalid = 0;
        tick;
        tick;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b100) begin
            errors++;
            $display("FAIL strobe_w_held: aw/w ready,bvalid %b want 100", {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        s_axi_awaddr = 7'h0C; s_axi_awvalid = 1;
        tick;
        s_axi_awvalid = 0;
        tick;
        exp_r[3] = 32'h1111_FF11;
        vectors++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || wr_pulse !== 16'h0008 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL strobe_commit: bvalid=%b bresp=%b pulse=%h reg3=%h want 1 00 0008 1111ff11",
                     s_axi_bvalid, s_axi_bresp, wr_pulse, slv_reg[96+:32]);
        end
        s_axi_bready = 1;
        tick;
        s_axi_bready = 0;
    endtask

    task automatic test_readonly;
        logic [31:0] d;
        logic [1:0] resp;
        bit ok;
        rd(7'h00, d, resp, ok);
        vectors++;
        if (!ok || d !== 32'hDEAD_BEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL ro_read0: ok=%0d rdata=%h rresp=%b want 1 deadbeef 00", ok, d, resp);
        end
        rd(7'h06, d, resp, ok);
        vectors++;
        if (!ok || d !== 32'hCAFE_0001 || resp !== 2'b00) begin
            errors++;
            $display("FAIL ro_read1: ok=%0d rdata=%h rresp=%b want 1 cafe0001 00", ok, d, resp);
        end
        rd(7'h08, d, resp, ok);
        vectors++;
        if (!ok || d !== 32'hA5A5_1234 || resp !== 2'b00) begin
            errors++;
            $display("FAIL rw_read2: ok=%0d rdata=%h rresp=%b want 1 a5a51234 00", ok, d, resp);
        end
        wr(7'h00, 32'h1234_5678, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL ro_write0: ok=%0d bresp=%b reg0=%h want 1 00 00000000", ok, resp, slv_reg[31:0]);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic [1:0] resp;
        bit ok;
        rd(7'h40, d, resp, ok);
        vectors++;
        if (!ok || d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: ok=%0d rdata=%h rresp=%b want 1 00000000 10", ok, d, resp);
        end
        wr(7'h40, 32'hFFFF_FFFF, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b10 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL oor_write: ok=%0d bresp=%b regs changed=%0d want 1 10 0", ok, resp, slv_reg !== packed_exp());
        end
        wr(7'h3E, 32'hBEEF_0015, 4'h3, resp, ok);
        exp_r[15] = 32'h0000_0015;
        vectors++;
        if (!ok || resp !== 2'b00 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL last_reg_write: ok=%0d bresp=%b reg15=%h want 1 00 00000015", ok, resp, slv_reg[480+:32]);
        end
    endtask

    task automatic test_bready_stall;
        s_axi_awaddr = 7'h10; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        tick;
        exp_r[4] = 32'h5;
        s_axi_awaddr = 7'h14; s_axi_wdata = 32'h6;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
                errors++;
                $display("FAIL stall_cycle%0d: bvalid/awready/wready %b want 100", i,
                         {s_axi_bvalid, s_axi_awready, s_axi_wready});
            end
            tick;
        end
        s_axi_bready = 1;
        tick;
        s_axi_bready = 0;
        vectors++;
        if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: bvalid/awready %b want 01", {s_axi_bvalid, s_axi_awready});
        end
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        tick;
        exp_r[5] = 32'h6;
        vectors++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || wr_pulse !== 16'h0020 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL stall_next_write: bvalid=%b pulse=%h reg5=%h want 1 0020 00000006",
                     s_axi_bvalid, wr_pulse, slv_reg[160+:32]);
        end
        s_axi_bready = 1;
        tick;
        s_axi_bready = 0;
    endtask

    task automatic test_concurrent;
        s_axi_awaddr = 7'h18; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 7'h18; s_axi_arvalid = 1;
        tick;
        s_axi_arvalid = 0;
        exp_r[6] = 32'h77;
        vectors++;
        if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h0 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL same_edge_rw: bvalid=%b rvalid=%b rdata=%h reg6=%h want 1 1 00000000 00000077",
                     s_axi_bvalid, s_axi_rvalid, s_axi_rdata, slv_reg[192+:32]);
        end
        s_axi_bready = 1; s_axi_rready = 1;
        tick;
        s_axi_bready = 0; s_axi_rready = 0;
        vectors++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL same_edge_done: bvalid/rvalid %b want 00", {s_axi_bvalid, s_axi_rvalid});
        end
    endtask

    task automatic test_reset_midflight;
        s_axi_awaddr = 7'h1C; s_axi_wdata = 32'h99; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        tick;
        vectors++;
        if (s_axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup: bvalid %b want 1", s_axi_bvalid);
        end
        #1 axi_areset = 1;
        #1;
        for (int i = 0; i < N; i++) exp_r[i] = '0;
        vectors++;
        if (s_axi_bvalid !== 1'b0 || slv_reg !== packed_exp() || s_axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: bvalid=%b awready=%b slv_reg nonzero=%0d want 0 0 0",
                     s_axi_bvalid, s_axi_awready, slv_reg !== packed_exp());
        end
        #1 axi_areset = 0;
        tick;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL midflight_release: aw/w/ar ready,bvalid %b want 1110",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
        end
        tick;
        tick;
        vectors++;
        if (s_axi_bvalid !== 1'b0 || slv_reg !== packed_exp()) begin
            errors++;
            $display("FAIL midflight_no_resp: bvalid=%b want 0 and regs 0", s_axi_bvalid);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_r[i] = '0;
            slv_read[32*i+:32] = 32'hCAFE_0000 | i;
        end
        slv_read[31:0] = 32'hDEAD_BEEF;
        test_reset;
        test_same_cycle;
        test_strobe;
        test_readonly;
        test_out_of_range;
        test_bready_stall;
        test_concurrent;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
